// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch (IF)
// and the data-memory stage (DM); one transaction at a time, sticky timeout flag.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
);
    // state | meaning
    // IDLE  | no transaction; arbitrates and grants on the next edge
    // BUSY  | mem_req_o high, waiting for mem_ack_i or timeout
    // RESP  | one-cycle ack to the owner; requests are not sampled
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int               CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                owner_dm_q, owner_dm_d;
    logic                last_dm_q, last_dm_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                dm_ack_q, dm_ack_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                grant_dm;
    logic [DATA_W-1:0]   rdata_cap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_dm_q  <= 1'b0;
            last_dm_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            last_dm_q   <= last_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        last_dm_d   = last_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        // On a tie DM wins unless it was the last one served.
        grant_dm    = dm_req_i & (~if_req_i | ~last_dm_q);
        rdata_cap   = '0;

        unique case (state_q)
            IDLE: begin
                if (if_req_i | dm_req_i) begin
                    owner_dm_d  = grant_dm;
                    mem_addr_d  = grant_dm ? dm_addr_i : if_addr_i;
                    mem_we_d    = grant_dm & dm_we_i;
                    mem_wdata_d = grant_dm ? dm_wdata_i : '0;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ack_i || (cnt_q == CNT_LAST)) begin
                    if (mem_ack_i) begin
                        rdata_cap = mem_we_q ? '0 : mem_rdata_i;
                        last_dm_d = owner_dm_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (owner_dm_q) begin
                        dm_rdata_d = rdata_cap;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = rdata_cap;
                        if_ack_d   = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;
    assign stall_o     = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Arbitrates one single-ported, variable-latency memory between two requesters: the instruction-fetch (IF) path and the data-memory (MEM stage) path of the 5-stage pipeline.
- Serves one transaction at a time.
- Drives a pipeline stall while any request is outstanding.
- Flags a sticky error when the memory fails to acknowledge within a bounded time.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum wait in cycles for mem_ack_i after mem_req_o rises; legal range 1..65535.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- if_req_i  in  1  IF read request; level, held until if_ack_o.
- if_addr_i  in  ADDR_W  IF read address.
- if_rdata_o  out  DATA_W  IF read data; valid while if_ack_o=1.
- if_ack_o  out  1  one-cycle IF completion pulse.
- dm_req_i  in  1  data request; level, held until dm_ack_o.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  write data.
- dm_rdata_o  out  DATA_W  data read result; valid while dm_ack_o=1.
- dm_ack_o  out  1  one-cycle data completion pulse.
- stall_o  out  1  pipeline stall request.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data.
- mem_ack_i  in  1  memory completion, one-cycle pulse.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - FSM to IDLE; last_grant to IF.
  - All outputs 0, including err_o; timeout counter 0.
  - Any in-flight memory transaction is abandoned.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only one requester active: grant it.
  - Both active: grant the requester other than last_grant (alternation); from reset, DM wins the first tie.
  - On grant, the same edge registers owner, mem_addr_o, mem_we_o (0 for IF), mem_wdata_o, sets mem_req_o=1, clears the counter and moves to BUSY.
  - Grant latency: 1 cycle from request to mem_req_o.
- BUSY:
  - mem_req_o and the registered address, data and we stay stable, even if the requester's inputs change.
  - The counter increments each cycle.
  - On mem_ack_i: capture mem_rdata_i into the owner's rdata register (reads only; writes capture 0), drop mem_req_o, update last_grant, go to RESP.
  - If the counter reaches TIMEOUT with no ack: set err_o, capture rdata 0, drop mem_req_o, go to RESP.
- RESP:
  - The owner's ack_o is 1 for exactly this cycle; the other ack is 0.
  - New requests are not sampled in this state, so a requester still holding req during its ack cycle is not re-granted.
  - Next state is IDLE.
- Minimum transaction length: IDLE → BUSY → (ack) → RESP, i.e. 3 cycles from request to ack with a zero-wait memory.
- mem_ack_i seen in IDLE or RESP is ignored and does not set err_o.
- rdata outputs hold their last value after ack; only the ack-cycle value is specified.
- stall_o is combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
- err_o clears only on reset.
- A request dropped before its ack is a protocol violation.
  - If dropped before grant: it is simply not served.
  - If dropped after grant: the transaction still completes and acks.

Test Plan:
- Single IF read: if_req_i=1, if_addr_i=0x0000_0010, memory acks on the 2nd BUSY cycle with 0x8C22_0004 → mem_req_o rises 1 cycle after request; if_ack_o pulses 1 cycle with if_rdata_o=0x8C22_0004; stall_o=0 in the cycle after the ack.
- Data write: dm_req_i=1, dm_we_i=1, addr 0x20, wdata 0xDEAD_BEEF, zero-wait ack → mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0xDEAD_BEEF; dm_ack_o on the 3rd cycle; dm_rdata_o=0.
- Simultaneous requests, both held for 4 transactions: first grant after reset goes to DM, then IF, then DM, then IF → ack order alternates, each ack a 1-cycle pulse, never both acks high together.
- Held request during RESP: requester keeps if_req_i=1 through its ack cycle and drops it the next cycle → exactly one memory transaction (mem_req_o rises once).
- Timeout with TIMEOUT=4 and mem_ack_i never asserted → err_o=1 after 4 BUSY cycles; dm_ack_o pulses with dm_rdata_o=0; a following transaction still works and err_o stays 1.
- Reset mid-BUSY: rst_i pulsed while mem_req_o=1 → mem_req_o, acks and err_o go to 0 immediately; a late mem_ack_i is ignored; the next request is granted normally.
